// File: rtl/rb_write_ctrl_if.sv
// Bundle of the pixel input stream, row-buffer memory port and window-column output of rb_write_ctrl.
// Both streams use valid/ready: a beat transfers on a rising edge where valid && ready; valid may not depend on ready.
interface rb_write_ctrl_if #(
  parameter int PIXEL_BITS  = 8,
  parameter int IMAGE_WIDTH = 256,
  parameter int RB_COUNT    = 8
);
  localparam int AW = $clog2(RB_COUNT * IMAGE_WIDTH);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int SW = $clog2(RB_COUNT);

  logic                  in_valid;
  logic                  in_ready;
  logic [PIXEL_BITS-1:0] in_data;
  logic                  in_sof;
  logic                  mem_we;
  logic [AW-1:0]         mem_write_addr;
  logic [PIXEL_BITS-1:0] mem_write_data;
  logic                  mem_re;
  logic [CW-1:0]         mem_read_addr;
  logic                  win_valid;
  logic                  out_ready;
  logic [PIXEL_BITS-1:0] win_pixel;
  logic [CW-1:0]         win_col;
  logic [SW-1:0]         win_oldest;
  logic                  win_primed;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, mem_we, mem_write_addr, mem_write_data, mem_re, mem_read_addr,
    output win_valid, win_pixel, win_col, win_oldest, win_primed
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, mem_we, mem_write_addr, mem_write_data, mem_re, mem_read_addr,
    input  win_valid, win_pixel, win_col, win_oldest, win_primed
  );
endinterface

// File: rtl/rb_write_ctrl.sv
// Raster writer / column-read sequencer for the interleaved row buffer (word = col*RB_COUNT + slot).
// Optional short-line detection is built only when RB_SHORT_LINE_ERR_EN is defined.
module rb_write_ctrl #(
  parameter int PIXEL_BITS  = 8,
  parameter int IMAGE_WIDTH = 256,
  parameter int KERNEL_SIZE = 9,
  parameter int RB_COUNT    = KERNEL_SIZE - 1
) (
  input  logic                clk,
  input  logic                rst,
  rb_write_ctrl_if.slave      bus,
  output logic                err_short_line,
  output logic [1:0]          dbg_state
);
  localparam int AW = $clog2(RB_COUNT * IMAGE_WIDTH);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int SW = $clog2(RB_COUNT);
  localparam int LW = $clog2(RB_COUNT + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMAGE_WIDTH - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(RB_COUNT - 1);
  localparam logic [LW-1:0] FULL      = LW'(RB_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         col;
  logic [SW-1:0]         slot;
  logic [LW-1:0]         lines;
  logic                  win_valid_q;
  logic [PIXEL_BITS-1:0] win_pixel_q;
  logic [CW-1:0]         win_col_q;
  logic [SW-1:0]         win_oldest_q;
  logic                  win_primed_q;

  logic                  ready;
  logic                  acc;
  logic                  proc;
  logic                  last;
  logic [CW-1:0]         eff_col;
  logic [SW-1:0]         eff_slot;
  logic [LW-1:0]         eff_lines;
  logic [LW-1:0]         next_lines;

  // A start-of-frame pixel is processed as if the counters were already cleared.
  always_comb begin
    ready      = !win_valid_q || bus.out_ready;
    acc        = bus.in_valid && ready;
    proc       = acc && (bus.in_sof || state != IDLE);
    eff_col    = bus.in_sof ? '0 : col;
    eff_slot   = bus.in_sof ? '0 : slot;
    eff_lines  = bus.in_sof ? '0 : lines;
    last       = (eff_col == LAST_COL);
    next_lines = (eff_lines == FULL) ? FULL : eff_lines + LW'(1);
  end

  assign bus.in_ready       = ready;
  assign bus.mem_we         = proc;
  assign bus.mem_re         = proc;
  assign bus.mem_write_addr = AW'(eff_col) * AW'(RB_COUNT) + AW'(eff_slot);
  assign bus.mem_write_data = bus.in_data;
  assign bus.mem_read_addr  = eff_col;
  assign bus.win_valid      = win_valid_q;
  assign bus.win_pixel      = win_pixel_q;
  assign bus.win_col        = win_col_q;
  assign bus.win_oldest     = win_oldest_q;
  assign bus.win_primed     = win_primed_q;
  assign dbg_state          = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      slot         <= '0;
      lines        <= '0;
      win_valid_q  <= 1'b0;
      win_pixel_q  <= '0;
      win_col_q    <= '0;
      win_oldest_q <= '0;
      win_primed_q <= 1'b0;
    end else begin
      if (proc) begin
        win_valid_q  <= 1'b1;
        win_pixel_q  <= bus.in_data;
        win_col_q    <= eff_col;
        win_oldest_q <= eff_slot;
        win_primed_q <= (eff_lines == FULL);
        if (last) begin
          col   <= '0;
          slot  <= (eff_slot == LAST_SLOT) ? '0 : eff_slot + SW'(1);
          lines <= next_lines;
          state <= (next_lines == FULL) ? STREAM : FILL;
        end else begin
          col   <= eff_col + CW'(1);
          slot  <= eff_slot;
          lines <= eff_lines;
          state <= (eff_lines == FULL) ? STREAM : FILL;
        end
      end else if (bus.out_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

`ifdef RB_SHORT_LINE_ERR_EN
  // A new frame arriving part-way through a line means the previous line was short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_short_line <= 1'b0;
    end else if (acc && bus.in_sof && state != IDLE && col != '0) begin
      err_short_line <= 1'b1;
    end
  end
`else
  assign err_short_line = 1'b0;
`endif
endmodule

// File: tb/tb_rb_write_ctrl.sv
// Bench for rb_write_ctrl with IMAGE_WIDTH=4, RB_COUNT=2 and a behavioural row-buffer memory.
module tb_rb_write_ctrl;
  localparam int PB = 8;
  localparam int W  = 4;
  localparam int RB = 2;
`ifdef RB_SHORT_LINE_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       err;
  logic [1:0] dbg;

  rb_write_ctrl_if #(.PIXEL_BITS(PB), .IMAGE_WIDTH(W), .RB_COUNT(RB)) bus ();

  rb_write_ctrl #(.PIXEL_BITS(PB), .IMAGE_WIDTH(W), .KERNEL_SIZE(RB + 1)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .err_short_line (err),
    .dbg_state      (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // row-buffer memory: registered read of all slots, read sees pre-write data
  logic [PB-1:0] mem [0:RB*W-1];
  logic [PB-1:0] rd  [0:RB-1];
  always @(posedge clk) begin
    if (bus.mem_re)
      for (int s = 0; s < RB; s++) rd[s] <= mem[int'(bus.mem_read_addr) * RB + s];
    if (bus.mem_we) mem[bus.mem_write_addr] <= bus.mem_write_data;
  end

  // scoreboard
  typedef struct packed {
    logic [PB-1:0] pix;
    logic [1:0]    col;
    logic          oldest;
    logic          primed;
    logic          chk_rd;
    logic [PB-1:0] old;
  } win_t;
  win_t exp_q[$];

  logic [PB-1:0] shadow   [0:RB*W-1];
  logic          shadow_v [0:RB*W-1];
  logic          m_wv;
  int            checks;
  int            failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus with the caller's expectation for this cycle
  task automatic drive(input logic v, input logic sof, input logic [PB-1:0] d, input logic ordy,
                       input logic proc, input logic [2:0] waddr, input logic [1:0] col,
                       input logic oldest, input logic primed);
    win_t e;
    win_t h;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sof    = sof;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, !m_wv || ordy);
    chk("mem_we", bus.mem_we, proc);
    chk("mem_re", bus.mem_re, proc);
    chk("win_valid", bus.win_valid, m_wv);
    if (m_wv) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        h = exp_q[0];
        chk("win_pixel", bus.win_pixel, h.pix);
        chk("win_col", bus.win_col, h.col);
        chk("win_oldest", bus.win_oldest, h.oldest);
        chk("win_primed", bus.win_primed, h.primed);
        if (h.chk_rd) chk("read_data_oldest", rd[h.oldest], h.old);
        if (ordy) void'(exp_q.pop_front());
      end
    end
    if (proc) begin
      chk("mem_write_addr", bus.mem_write_addr, waddr);
      chk("mem_read_addr", bus.mem_read_addr, col);
      chk("mem_write_data", bus.mem_write_data, d);
      e.pix    = d;
      e.col    = col;
      e.oldest = oldest;
      e.primed = primed;
      e.chk_rd = primed && shadow_v[waddr];
      e.old    = shadow[waddr];
      shadow[waddr]   = d;
      shadow_v[waddr] = 1'b1;
      exp_q.push_back(e);
    end
    m_wv = proc ? 1'b1 : (ordy ? 1'b0 : m_wv);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_write_addr", bus.mem_write_addr, 0);
    chk("rst_mem_read_addr", bus.mem_read_addr, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_win_pixel", bus.win_pixel, 0);
    chk("rst_win_col", bus.win_col, 0);
    chk("rst_win_oldest", bus.win_oldest, 0);
    chk("rst_win_primed", bus.win_primed, 0);
    chk("rst_err_short_line", err, 0);
  endtask

  typedef struct {
    logic          v;
    logic          sof;
    logic [PB-1:0] d;
    logic          ordy;
    logic          proc;
    logic [2:0]    waddr;
    logic [1:0]    col;
    logic          oldest;
    logic          primed;
  } vec_t;
  vec_t tbl [0:15];

  initial begin
    checks   = 0;
    failures = 0;
    m_wv     = 1'b0;
    for (int i = 0; i < RB * W; i++) begin
      shadow[i]   = '0;
      shadow_v[i] = 1'b0;
      mem[i]      = '0;
    end
    // v sof data ordy | proc waddr col oldest primed
    tbl[0]  = '{1, 1, 8'd10, 1, 1, 3'd0, 2'd0, 0, 0};
    tbl[1]  = '{1, 0, 8'd11, 1, 1, 3'd2, 2'd1, 0, 0};
    tbl[2]  = '{1, 0, 8'd12, 1, 1, 3'd4, 2'd2, 0, 0};
    tbl[3]  = '{1, 0, 8'd13, 1, 1, 3'd6, 2'd3, 0, 0};
    tbl[4]  = '{0, 0, 8'd0,  1, 0, 3'd0, 2'd0, 0, 0};
    tbl[5]  = '{1, 0, 8'd20, 1, 1, 3'd1, 2'd0, 1, 0};
    tbl[6]  = '{1, 0, 8'd21, 1, 1, 3'd3, 2'd1, 1, 0};
    tbl[7]  = '{1, 0, 8'd22, 1, 1, 3'd5, 2'd2, 1, 0};
    tbl[8]  = '{1, 0, 8'd23, 1, 1, 3'd7, 2'd3, 1, 0};
    tbl[9]  = '{1, 0, 8'd30, 1, 1, 3'd0, 2'd0, 0, 1};
    tbl[10] = '{1, 0, 8'd31, 1, 1, 3'd2, 2'd1, 0, 1};
    tbl[11] = '{1, 0, 8'd32, 1, 1, 3'd4, 2'd2, 0, 1};
    tbl[12] = '{1, 0, 8'd33, 1, 1, 3'd6, 2'd3, 0, 1};
    tbl[13] = '{1, 0, 8'd40, 1, 1, 3'd1, 2'd0, 1, 1};
    tbl[14] = '{1, 0, 8'd41, 1, 1, 3'd3, 2'd1, 1, 1};
    tbl[15] = '{0, 0, 8'd0,  1, 0, 3'd0, 2'd0, 0, 0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;

    // pixels before any start of frame are dropped
    for (int i = 0; i < 5; i++)
      drive(1, 0, PB'($urandom_range(1, 255)), 1, 0, 3'd0, 2'd0, 0, 0);

    // three lines to fill and prime, plus the start of a fourth
    for (int i = 0; i < 16; i++)
      drive(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].ordy, tbl[i].proc,
            tbl[i].waddr, tbl[i].col, tbl[i].oldest, tbl[i].primed);

    // backpressure: one accept, then held for two cycles, then release
    drive(1, 0, 8'd42, 0, 1, 3'd5, 2'd2, 1, 1);
    drive(1, 0, 8'd43, 0, 0, 3'd0, 2'd0, 0, 0);
    drive(1, 0, 8'd43, 0, 0, 3'd0, 2'd0, 0, 0);
    drive(1, 0, 8'd43, 1, 1, 3'd7, 2'd3, 1, 1);

    // short line: start of frame arrives at column 2
    drive(1, 0, 8'd50, 1, 1, 3'd0, 2'd0, 0, 1);
    drive(1, 0, 8'd51, 1, 1, 3'd2, 2'd1, 0, 1);
    drive(1, 1, 8'd60, 1, 1, 3'd0, 2'd0, 0, 0);
    drive(1, 0, 8'd61, 1, 1, 3'd2, 2'd1, 0, 0);
    chk("err_short_line", err, EXP_ERR);

    // reset in the middle of a stream
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst          = 1'b1;
    #1;
    chk_reset();
    exp_q.delete();
    m_wv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 8'd70, 1, 0, 3'd0, 2'd0, 0, 0);
    drive(1, 0, 8'd71, 1, 0, 3'd0, 2'd0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 3'd0, 2'd0, 0, 0);
    chk("err_after_reset", err, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
